dsp_lane_arbiter: RTL and testbench

Shares the fixed pool of DSP multiplier lanes (the 5-lane operand/product interface driven by the convolution engine) between several compute engines, such as the convolution and matrix-multiply units. A requester holds the pool for a whole job. The arbiter muxes the owner's lane operands and clock-enable onto the DSP pool, and broadcasts the products back. When ownership changes, it flushes the DSP pipeline so in-flight products never reach the wrong engine. Arbitration is round-robin.

---
 rtl/dsp_lane_arbiter.sv | 149 ++++++++++++++
 tb/tb_dsp_lane_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dsp_lane_arbiter.sv
// dsp_lane_arbiter: round-robin owner of the shared DSP lane pool.
// Ports: req/req_ce/req_a/req_b per engine in; grant/owner/busy,
//   dsp_a/dsp_b/dsp_ce to the pool; dsp_out in, resp_p broadcast out;
//   grant_cycles saturating occupancy counter.
module dsp_lane_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int LANES    = 5,
   parameter int OP_W     = 18,
   parameter int P_W      = 37,
   parameter int PIPE_LAT = 2,
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    req,
   input  logic [NUM_REQ-1:0]                    req_ce,
   input  logic [NUM_REQ-1:0][LANES-1:0][OP_W-1:0] req_a,
   input  logic [NUM_REQ-1:0][LANES-1:0][OP_W-1:0] req_b,
   output logic [NUM_REQ-1:0]                    grant,
   output logic [OW-1:0]                         owner,
   output logic                                  busy,
   output logic [LANES-1:0][OP_W-1:0]            dsp_a,
   output logic [LANES-1:0][OP_W-1:0]            dsp_b,
   output logic                                  dsp_ce,
   input  logic [LANES-1:0][P_W-1:0]             dsp_out,
   output logic [LANES-1:0][P_W-1:0]             resp_p,
   output logic [31:0]                           grant_cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [OW-1:0]        rr_ptr, rr_d;
   logic [OW-1:0]        owner_d;
   logic [2:0]           drain_cnt, drain_d;
   logic [NUM_REQ-1:0]   grant_d;
   logic [31:0]          gc_d;

   logic                 any_req;
   logic                 found;
   logic [OW-1:0]        win;
   logic [OW-1:0]        idx;
   logic [OW-1:0]        rr_nxt;
   logic [NUM_REQ-1:0]   win_oh;

   assign any_req = |req;
   assign busy    = (state_q != IDLE);
   assign resp_p  = dsp_out;

   // Scan upward from rr_ptr with wrap; first requester found wins.
   always_comb begin
      found  = 1'b0;
      win    = '0;
      idx    = '0;
      win_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = OW'((int'(rr_ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      win_oh[win] = 1'b1;
      rr_nxt = OW'((int'(win) + 1) % NUM_REQ);
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant;
      owner_d = owner;
      rr_d    = rr_ptr;
      drain_d = drain_cnt;
      gc_d    = grant_cycles;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d = win;
               grant_d = win_oh;
               rr_d    = rr_nxt;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (grant_cycles != 32'hFFFF_FFFF)
               gc_d = grant_cycles + 32'd1;
            if (!req[owner]) begin
               grant_d = '0;
               drain_d = 3'(PIPE_LAT - 1);
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt == 3'd0) begin
               // Hand straight to the next winner; no idle bubble.
               if (any_req) begin
                  owner_d = win;
                  grant_d = win_oh;
                  rr_d    = rr_nxt;
                  state_d = GRANT;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               drain_d = drain_cnt - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Zero operands with ce high during DRAIN flush stale products.
   always_comb begin
      dsp_a  = '0;
      dsp_b  = '0;
      dsp_ce = 1'b0;
      unique case (state_q)
         GRANT: begin
            dsp_a  = req_a[owner];
            dsp_b  = req_b[owner];
            dsp_ce = req_ce[owner];
         end
         DRAIN:   dsp_ce = 1'b1;
         default: dsp_ce = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant        <= '0;
         owner        <= '0;
         rr_ptr       <= '0;
         drain_cnt    <= '0;
         grant_cycles <= '0;
      end else begin
         state_q      <= state_d;
         grant        <= grant_d;
         owner        <= owner_d;
         rr_ptr       <= rr_d;
         drain_cnt    <= drain_d;
         grant_cycles <= gc_d;
      end
   end

endmodule

// File: tb/tb_dsp_lane_arbiter.sv
// tb_dsp_lane_arbiter: directed scoreboard bench for dsp_lane_arbiter.
// Two requesters, five lanes, PIPE_LAT=2.
module tb_dsp_lane_arbiter;

   logic                      clk;
   logic                      rst;
   logic [1:0]                req;
   logic [1:0]                req_ce;
   logic [1:0][4:0][17:0]     req_a;
   logic [1:0][4:0][17:0]     req_b;
   logic [1:0]                grant;
   logic [0:0]                owner;
   logic                      busy;
   logic [4:0][17:0]          dsp_a;
   logic [4:0][17:0]          dsp_b;
   logic                      dsp_ce;
   logic [4:0][36:0]          dsp_out;
   logic [4:0][36:0]          resp_p;
   logic [31:0]               grant_cycles;

   dsp_lane_arbiter #(
      .NUM_REQ(2), .LANES(5), .OP_W(18), .P_W(37), .PIPE_LAT(2)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_ce(req_ce),
      .req_a(req_a), .req_b(req_b), .grant(grant), .owner(owner),
      .busy(busy), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ce(dsp_ce),
      .dsp_out(dsp_out), .resp_p(resp_p), .grant_cycles(grant_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   g;
      logic         bz;
      logic         ow;
      logic         ce;
      logic [89:0]  a;
      logic [89:0]  b;
      logic [184:0] p;
      logic [31:0]  gc;
      logic         cg;
   } exp_t;

   exp_t         sbq[$];
   int           vecs = 0;
   int           miss = 0;
   int           stepn = 0;
   logic [89:0]  pat0a, pat0b, ones;

   task automatic chk(input string tag, input logic [191:0] o,
                      input logic [191:0] x);
      vecs++;
      assert (o === x) else begin
         miss++;
         $error("FAIL %s step=%0d obs=%0h exp=%0h", tag, stepn, o, x);
      end
   endtask

   // Drive one cycle of inputs, queue what the DUT must show after the
   // next edge, then pop and compare once it has settled.
   task automatic step(input logic rs, input logic [1:0] r,
                       input logic [1:0] c, input logic [1:0] g,
                       input logic bz, input logic ow, input logic ece,
                       input int m, input logic [31:0] gc,
                       input logic cg);
      exp_t         e;
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rst     = rs;
      req     = r;
      req_ce  = c;
      dsp_out = t[184:0];
      e.g  = g;
      e.bz = bz;
      e.ow = ow;
      e.ce = ece;
      e.a  = (m == 1) ? pat0a : (m == 2) ? ones : '0;
      e.b  = (m == 1) ? pat0b : (m == 2) ? ones : '0;
      e.p  = t[184:0];
      e.gc = gc;
      e.cg = cg;
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      stepn++;
      e = sbq.pop_front();
      chk("grant", 192'(grant), 192'(e.g));
      chk("busy", 192'(busy), 192'(e.bz));
      chk("owner", 192'(owner), 192'(e.ow));
      chk("dsp_ce", 192'(dsp_ce), 192'(e.ce));
      chk("dsp_a", 192'(dsp_a), 192'(e.a));
      chk("dsp_b", 192'(dsp_b), 192'(e.b));
      chk("resp_p", 192'(resp_p), 192'(e.p));
      if (e.cg)
         chk("grant_cycles", 192'(grant_cycles), 192'(e.gc));
   endtask

   initial begin
      for (int k = 0; k < 5; k++) begin
         pat0a[k*18 +: 18] = 18'(k + 1);
         pat0b[k*18 +: 18] = 18'd3;
      end
      ones     = '1;
      req_a[0] = pat0a;
      req_b[0] = pat0b;
      req_a[1] = ones;
      req_b[1] = ones;
      rst      = 1'b1;
      req      = '0;
      req_ce   = '0;
      dsp_out  = '0;
      @(negedge clk);

      // reset state
      step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
      step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);

      // single requester, ce toggle 1,0,1, other side drives ones
      step(0, 2'b01, 2'b10 | 2'b01, 2'b01, 1, 0, 1, 1, 0, 1);
      step(0, 2'b01, 2'b10, 2'b01, 1, 0, 0, 1, 1, 1);
      step(0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 1, 2, 1);
      for (int i = 3; i < 10; i++)
         step(0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 1, 32'(i), 1);
      step(0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 10, 1);
      step(0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 10, 1);
      step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 10, 1);

      // contention from reset: rr_ptr back to 0, grants alternate
      step(1, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1);
      step(0, 2'b11, 2'b11, 2'b01, 1, 0, 1, 1, 0, 1);
      step(0, 2'b11, 2'b11, 2'b01, 1, 0, 1, 1, 1, 1);
      step(0, 2'b11, 2'b11, 2'b01, 1, 0, 1, 1, 2, 1);
      step(0, 2'b10, 2'b11, 2'b00, 1, 0, 1, 0, 3, 1);
      step(0, 2'b11, 2'b11, 2'b00, 1, 0, 1, 0, 3, 1);
      step(0, 2'b11, 2'b11, 2'b10, 1, 1, 1, 2, 3, 1);
      step(0, 2'b11, 2'b01, 2'b10, 1, 1, 0, 2, 4, 1);
      step(0, 2'b01, 2'b11, 2'b00, 1, 1, 1, 0, 5, 1);
      step(0, 2'b11, 2'b11, 2'b00, 1, 1, 1, 0, 5, 1);
      step(0, 2'b11, 2'b11, 2'b01, 1, 0, 1, 1, 5, 1);

      // reset mid-GRANT, then mid-DRAIN
      step(1, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1);
      step(0, 2'b11, 2'b11, 2'b01, 1, 0, 1, 1, 0, 1);
      step(0, 2'b10, 2'b11, 2'b00, 1, 0, 1, 0, 1, 1);
      step(1, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1);
      step(0, 2'b11, 2'b11, 2'b01, 1, 0, 1, 1, 0, 1);

      // req[1] rises during DRAIN, handoff with no idle cycle
      step(0, 2'b01, 2'b11, 2'b01, 1, 0, 1, 1, 1, 1);
      step(0, 2'b00, 2'b11, 2'b00, 1, 0, 1, 0, 2, 1);
      step(0, 2'b10, 2'b11, 2'b00, 1, 0, 1, 0, 2, 1);
      step(0, 2'b10, 2'b11, 2'b10, 1, 1, 1, 2, 2, 1);
      // req[0] pulses while 1 owns: never granted
      step(0, 2'b11, 2'b11, 2'b10, 1, 1, 1, 2, 3, 1);
      step(0, 2'b10, 2'b11, 2'b10, 1, 1, 1, 2, 4, 1);
      step(0, 2'b00, 2'b11, 2'b00, 1, 1, 1, 0, 5, 1);
      step(0, 2'b00, 2'b11, 2'b00, 1, 1, 1, 0, 5, 1);
      step(0, 2'b00, 2'b11, 2'b00, 0, 1, 0, 0, 5, 1);

      // saturation
      step(0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 1, 5, 1);
      force dut.grant_cycles = 32'hFFFF_FFFE;
      step(0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 1, 0, 0);
      release dut.grant_cycles;
      step(0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 1, 32'hFFFF_FFFF, 1);
      step(0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 1, 32'hFFFF_FFFF, 1);
      step(0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 1, 32'hFFFF_FFFF, 1);
      step(0, 2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 32'hFFFF_FFFF, 1);
      step(0, 2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 32'hFFFF_FFFF, 1);
      step(0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
